// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// MSB first; divide-by-zero short-circuits straight to DONE.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             last;

  // one trial subtraction; a clear borrow bit means R >= divisor
  always_comb begin
    trial  = {rem_q, dvd[WIDTH-1]};
    diff   = trial - {1'b0, dvs};
    ge     = ~diff[WIDTH];
    rem_nx = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], ge};
    last   = (cnt == LAST);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic; requests are only taken in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd       <= '0;
      dvs       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd   <= dividend;
            dvs   <= divisor;
            rem_q <= '0;
            quo_q <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd   <= {dvd[WIDTH-2:0], 1'b0};
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (last) begin
            quotient  <= quo_nx;
            remainder <= rem_nx;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8).
// Expected results are queued at request time, checked on done.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;

  int checks;
  int fails;
  int dones;
  int cyc;

  logic [16:0] sb[$];
  int          done_t[$];

  seq_divider #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [7:0] a,
                                        input logic [7:0] b);
    if (b == 8'd0) return {8'hff, a, 1'b1};
    return {8'(a / b), 8'(a % b), 1'b0};
  endfunction

  // scoreboard: pop and compare on every done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [16:0] e;
      dones++;
      done_t.push_back(cyc);
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e[16:9]);
        chk("remainder", remainder, e[8:1]);
        chk("div_zero", div_zero, e[0]);
      end
    end
  end

  // issue one request at a negedge; check latency and busy span
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int lat);
    int n;
    int bc;
    sb.push_back(model(a, b));
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    n  = 1;
    bc = busy ? 1 : 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
    chk("done_latency", n, lat);
    chk("busy_cycles", bc, lat);
    @(negedge clk);
    chk("busy_low_after", busy, 0);
  endtask

  initial begin
    int n;
    int d0;
    checks   = 0;
    fails    = 0;
    dones    = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", div_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd200, 8'd7, 9);
    run_op(8'd255, 8'd1, 9);
    run_op(8'd5, 8'd9, 9);
    run_op(8'd255, 8'd255, 9);
    run_op(8'd100, 8'd0, 1);
    run_op(8'd10, 8'd3, 9);

    // start pulse and operand changes mid-CALC are ignored
    d0 = dones;
    sb.push_back(model(8'd200, 8'd7));
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'd13;
    divisor  = 8'd2;
    chk("hold_quot", quotient, 3);
    chk("hold_rem", remainder, 1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ign_done_seen", done, 1);
    repeat (14) @(negedge clk);
    chk("ign_single_done", dones - d0, 1);
    chk("ign_idle", busy, 0);

    // reset mid-CALC aborts with no done
    d0 = dones;
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", dones - d0, 0);
    run_op(8'd60, 8'd8, 9);

    // random operands
    for (int i = 0; i < 20; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = (i % 7 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_op(a, b, (b == 8'd0) ? 1 : 9);
    end

    // start held high: back-to-back operations
    done_t.delete();
    d0 = dones;
    for (int i = 0; i < 3; i++) sb.push_back(model(8'd200, 8'd7));
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    n = 0;
    while (dones - d0 < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("b2b_dones", dones - d0, 3);
    repeat (14) @(negedge clk);
    chk("b2b_no_extra", dones - d0, 3);
    if (done_t.size() >= 3) begin
      chk("b2b_gap1", done_t[1] - done_t[0], 10);
      chk("b2b_gap2", done_t[2] - done_t[1], 10);
    end else begin
      chk("b2b_times", done_t.size(), 3);
    end

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
